// File: rtl/da_pkg.sv
// Shared defaults and FSM encoding for the distributed-arithmetic accumulator.
package da_pkg;

  // Default widths: sample bits, LUT partial-sum width and result width.
  localparam int DATA_W_DEF = 8;
  localparam int LUT_W_DEF  = 6;
  localparam int ACC_W_DEF  = LUT_W_DEF + DATA_W_DEF;

  // 2-bit FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Width of the bit-slice index. Clamped to 1 so that a degenerate
  // one-bit sample still yields a legal vector.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/da_shift_add.sv
// Shift/add datapath: sign-extends the LUT partial sum, weights it by the
// current bit position and adds it to (or, for the sign bit, subtracts it
// from) the running accumulator.
module da_shift_add
  import da_pkg::*;
#(
  parameter int LUT_W = LUT_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SEL_W = sel_width(DATA_W_DEF)
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [LUT_W-1:0] lut,
  input  logic        [SEL_W-1:0] shift,
  input  logic                    sub,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [ACC_W-1:0] term;

  // Weighted partial sum and add/subtract select; the sign bit of a
  // two's-complement sample carries negative weight.
  always_comb begin
    term = {{(ACC_W-LUT_W){lut[LUT_W-1]}}, lut} <<< shift;
    sum  = sub ? (acc - term) : (acc + term);
  end

endmodule

// File: rtl/da_accumulator.sv
// Bit-serial distributed-arithmetic accumulator. One computation walks the
// sample bits LSB first, one bit per cycle, accumulating the LUT partial
// sums, then presents the result with a one-cycle valid strobe.
module da_accumulator
  import da_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int LUT_W  = LUT_W_DEF,
  parameter  int ACC_W  = LUT_W + DATA_W,
  localparam int SEL_W  = sel_width(DATA_W)
) (
  input  logic                    clk_80,
  input  logic                    rst_80,
  input  logic                    start_80,
  input  logic signed [LUT_W-1:0] lut_80,
  output logic        [SEL_W-1:0] bit_sel_80,
  output logic                    busy_80,
  output logic signed [ACC_W-1:0] y_80,
  output logic                    valid_80
);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic                    is_msb;

  assign is_msb = (bit_sel_80 == SEL_W'(DATA_W - 1));

  da_shift_add #(
    .LUT_W (LUT_W),
    .ACC_W (ACC_W),
    .SEL_W (SEL_W)
  ) u_shift_add (
    .acc   (acc),
    .lut   (lut_80),
    .shift (bit_sel_80),
    .sub   (is_msb),
    .sum   (acc_next)
  );

  // Status outputs decode straight from the state register so reset clears
  // them at once and valid_80 lasts exactly the single DONE cycle.
  assign busy_80  = (state == ST_RUN);
  assign valid_80 = (state == ST_DONE);

  // FSM, bit counter, accumulator and result register.
  // NOTE: every register here is assigned with <= so all of them update
  // from the same pre-edge values; blocking = would let later statements
  // see already-updated state and break the accumulate/compare ordering.
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      // NOTE: all state, including the result register, is cleared by the
      // asynchronous reset so outputs read zero while rst_80 is held.
      state      <= ST_IDLE;
      acc        <= '0;
      bit_sel_80 <= '0;
      y_80       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bit_sel_80 <= '0;
          if (start_80) begin
            state <= ST_RUN;
            acc   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          if (is_msb) begin
            y_80       <= acc_next;
            bit_sel_80 <= '0;
            state      <= ST_DONE;
          end else begin
            bit_sel_80 <= bit_sel_80 + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          bit_sel_80 <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_accumulator.sv
// Self-checking bench for da_accumulator: a LUT model drives lut_80 from
// bit_sel_80, every accepted start pushes the mathematically expected
// result into a scoreboard, and a monitor pops and compares on valid_80.
module tb_da_accumulator;

  localparam int DATA_W = 8;
  localparam int LUT_W  = 6;
  localparam int ACC_W  = 14;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic signed [LUT_W-1:0] lut;
  logic        [2:0]       bit_sel;
  logic                    busy;
  logic signed [ACC_W-1:0] y;
  logic                    valid;

  always #5 clk = ~clk;

  da_accumulator #(
    .DATA_W (DATA_W),
    .LUT_W  (LUT_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk_80     (clk),
    .rst_80     (rst),
    .start_80   (start),
    .lut_80     (lut),
    .bit_sel_80 (bit_sel),
    .busy_80    (busy),
    .y_80       (y),
    .valid_80   (valid)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // number of rising edges so far

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- LUT / slicer model ----------------
  // mode 0: lut value per bit slice taken from a table
  // mode 1: 4-tap DA filter; LUT address is the selected bit of each sample
  int                      mode = 0;
  logic signed [LUT_W-1:0] vals [DATA_W];
  logic signed [7:0]       xs   [4];
  int                      coef [4] = '{3, -5, 7, 2};
  logic signed [LUT_W-1:0] junk = '0;

  always @(negedge clk) junk = LUT_W'($urandom);

  always_comb begin
    int s;
    s   = 0;
    lut = junk;  // outside RUN the LUT input is arbitrary
    if (busy) begin
      if (mode == 0) begin
        lut = vals[bit_sel];
      end else begin
        for (int k = 0; k < 4; k++) s += xs[k][bit_sel] ? coef[k] : 0;
        lut = LUT_W'(s);
      end
    end
  end

  // Reference: value of the signed bit-sliced sum / the true dot product.
  function automatic int model();
    int r;
    r = 0;
    if (mode == 0) begin
      for (int i = 0; i < DATA_W - 1; i++) r += int'(vals[i]) * (1 << i);
      r -= int'(vals[DATA_W-1]) * (1 << (DATA_W - 1));
    end else begin
      for (int k = 0; k < 4; k++) r += coef[k] * int'(xs[k]);
    end
    return r;
  endfunction

  task automatic rand_vals();
    for (int i = 0; i < DATA_W; i++) vals[i] = LUT_W'($urandom);
  endtask

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    int y;
    int at;   // edge count at which valid must be visible
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   last_y   = 0;
  int   busy_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      last_y   = 0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("y", int'(y), e.y);
          check("valid_cycle", cyc, e.at);
        end
        check("busy_len", busy_cnt, DATA_W);
        busy_cnt = 0;
        last_y   = int'(y);
      end else begin
        check("y_hold", int'(y), last_y);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  // One computation; with noise, start toggles randomly during RUN.
  task automatic start_one(input bit noise);
    int a;
    @(negedge clk);
    start = 1'b1;
    a     = cyc + 1;
    q.push_back('{y: model(), at: a + DATA_W});
    for (int i = 0; i < DATA_W; i++) begin
      @(negedge clk);
      start = noise ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  // start held high: back-to-back results every DATA_W+1 cycles.
  task automatic back_to_back(input int n);
    int a;
    @(negedge clk);
    rand_vals();
    start = 1'b1;
    a     = cyc + 1;
    q.push_back('{y: model(), at: a + DATA_W});
    for (int k = 1; k < n; k++) begin
      while (cyc != a + (DATA_W + 1) * (k - 1) + DATA_W) @(negedge clk);
      rand_vals();
      q.push_back('{y: model(), at: a + (DATA_W + 1) * k + DATA_W});
    end
    while (cyc != a + (DATA_W + 1) * (n - 1) + DATA_W) @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  // Reset pulsed while bit_sel is 4; start held during reset.
  task automatic reset_mid_run();
    int a;
    @(negedge clk);
    rand_vals();
    start = 1'b1;
    a     = cyc + 1;
    q.push_back('{y: model(), at: a + DATA_W});
    @(negedge clk);
    start = 1'b0;
    while (cyc != a + 4) @(negedge clk);
    check("bit_sel_before_rst", int'(bit_sel), 4);
    #2;
    rst   = 1'b1;
    start = 1'b1;
    #1;
    check("rst_bit_sel", int'(bit_sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_y", int'(y), 0);
    q.delete();
    repeat (3) @(negedge clk);
    check("rst_held_busy", int'(busy), 0);
    start = 1'b0;
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_valid", int'(valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < DATA_W; i++) vals[i] = '0;
    for (int k = 0; k < 4; k++) xs[k] = '0;

    repeat (2) @(negedge clk);
    check("reset_y", int'(y), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_bit_sel", int'(bit_sel), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // All slices 7: 7*127 - 7*128
    for (int i = 0; i < DATA_W; i++) vals[i] = 6'sd7;
    start_one(1'b0);

    // Only LSB slice non-zero
    for (int i = 0; i < DATA_W; i++) vals[i] = '0;
    vals[0] = 6'sd1;
    start_one(1'b0);

    // Only MSB slice non-zero, negative: subtracted with weight 128
    for (int i = 0; i < DATA_W; i++) vals[i] = '0;
    vals[DATA_W-1] = -6'sd12;
    start_one(1'b0);

    // Slices 0..6 at 20, MSB slice 0
    for (int i = 0; i < DATA_W; i++) vals[i] = 6'sd20;
    vals[DATA_W-1] = '0;
    start_one(1'b0);

    // Random table slices, with start noise during RUN
    for (int n = 0; n < 20; n++) begin
      rand_vals();
      start_one(1'b1);
    end

    // Abort by reset, then a full restart
    reset_mid_run();
    rand_vals();
    start_one(1'b0);

    // Continuous start
    back_to_back(5);

    // End-to-end DA filter against a plain dot product
    mode = 1;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 4; k++) xs[k] = 8'($urandom);
      start_one(1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/da_accumulator.md
DA_ACCUMULATOR -- requirements
Module: da_accumulator

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, bits per input sample (number of bit-serial cycles per output).
REQ-002 LUT_W, default 6, width of signed partial-sum word from the coefficient LUT.
REQ-003 ACC_W, default LUT_W+DATA_W (14), width of signed result.
REQ-004 Ports SHALL be:
- clk_80  in  1  single clock, rising edge.
- rst_80  in  1  reset, asynchronous, active-high.
- start_80  in  1  request one DA computation.
- lut_80  in  LUT_W  signed LUT partial sum for the current bit slice (combinational from LUT).
- bit_sel_80  out  $clog2(DATA_W)  bit index the upstream slicer presents to the LUT address.
- busy_80  out  1  computation in progress.
- y_80  out  ACC_W  signed filter output.
- valid_80  out  1  one-cycle strobe, y_80 updated.

Function
REQ-005 FSM states SHALL be IDLE, RUN, DONE.
REQ-006 IDLE: start_80=1 at an edge -> RUN; acc cleared, bit_sel_80=0.
REQ-007 RUN: each edge, acc += sign_extend(lut_80) << bit_sel_80 for bit_sel_80 < DATA_W-1.
REQ-008 RUN, bit_sel_80 = DATA_W-1 (MSB): acc -= sign_extend(lut_80) << (DATA_W-1) (two's-complement MSB weight); result written to y_80; -> DONE.
REQ-009 bit_sel_80 SHALL increment by 1 per RUN cycle, LSB first, no wrap inside RUN; it is 0 in IDLE and DONE.
REQ-010 DONE: valid_80=1 for exactly this one cycle; start_80=1 -> RUN (back-to-back, acc cleared); else -> IDLE.
REQ-011 Latency: start accepted at edge 0 -> valid_80 high in the cycle after edge DATA_W (9 cycles for DATA_W=8); throughput one result per DATA_W+1 cycles.
REQ-012 start_80 during RUN SHALL be ignored (not queued).
REQ-013 busy_80 SHALL be 1 exactly in RUN.
REQ-014 y_80 SHALL hold its last value until the next DONE entry; never changes mid-RUN.
REQ-015 All arithmetic signed, ACC_W wide; no saturation (range proven to fit: |y| < 2^(ACC_W-1)).
REQ-016 lut_80 SHALL be sampled only in RUN; its value in IDLE/DONE has no effect.

Reset
REQ-017 rst_80 asserted SHALL immediately force: state IDLE, acc=0, bit_sel_80=0, busy_80=0, valid_80=0, y_80=0.
REQ-018 Reset mid-RUN SHALL abort the computation with no valid_80 pulse; next start after deassertion runs a full DATA_W-cycle computation.
REQ-019 start_80 SHALL be ignored while rst_80=1.

Structure
REQ-020 Shared package da_pkg SHALL hold DATA_W, LUT_W, ACC_W defaults and the FSM state encoding (2-bit: IDLE=0, RUN=1, DONE=2).
REQ-021 Shift/add datapath (sign-extend, shift by bit_sel, add/subtract select) SHALL be a sub-module da_shift_add; FSM and counter stay in da_accumulator.
REQ-022 The coefficient LUT is NOT instantiated here; the parent wires bit_sel_80 -> slicer -> LUT -> lut_80.

Verification
REQ-023 lut_80=7 for all 8 bits -> y_80 = 7*127 - 7*128 = -7, valid_80 one cycle, 9 cycles after start.
REQ-024 lut_80=1 at bit 0 only, 0 elsewhere -> y_80=1; lut_80=-12 at bit 7 only -> y_80=1536.
REQ-025 lut_80=20 bits 0..6, 0 at bit 7 -> y_80=2540; busy_80 high exactly 8 cycles.
REQ-026 rst_80 pulsed at bit_sel_80=4 -> all outputs 0 asynchronously, no valid_80; restart yields correct result.
REQ-027 start_80 held high continuously -> results every 9 cycles, start pulses during RUN ignored, y_80 stable between valid_80 strobes.
REQ-028 End-to-end: da_accumulator + slicer + coefficient LUT vs. software dot product for 1000 random signed 8-bit sample sets -> exact match.
